// File: rtl/router_out_arbiter.sv
// Per-output-port switch allocator: round-robin grant among N_REQ single-flit
// requesters, gated by downstream credits, with a registered output flit stage.
module router_out_arbiter #(
  parameter int N_REQ      = 5,
  parameter int FLIT_W     = 20,
  parameter int CREDIT_MAX = 4,
  localparam int CW        = $clog2(CREDIT_MAX + 1),
  localparam int PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*FLIT_W-1:0] flit_in,
  input  logic                    credit_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [FLIT_W-1:0]       o,
  output logic                    vo,
  output logic [CW-1:0]           credits,
  output logic                    credit_err
);

  localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic              found;
  logic [FLIT_W-1:0] win_flit;
  int                idx;

  // Scan from ptr upward with wrap; the first active requester wins.
  // Grants are suppressed while reset is held so gnt reads 0 in reset.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (!RST && credits != '0) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = int'(ptr) + i;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!found && req[idx]) begin
          found    = 1'b1;
          win      = PW'(idx);
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  assign win_flit = flit_in[int'(win)*FLIT_W +: FLIT_W];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ptr        <= '0;
      credits    <= CMAX;
      o          <= '0;
      vo         <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      vo <= found;
      if (found) begin
        o   <= win_flit;
        ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
      end
      // A grant and a returned credit in the same cycle cancel out.
      if (found && !credit_in) begin
        credits <= credits - CW'(1);
      end else if (!found && credit_in) begin
        if (credits == CMAX) credit_err <= 1'b1;
        else                 credits    <= credits + CW'(1);
      end
    end
  end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Per-output-port switch allocator for the 5-port mesh router. Arbitrates the five input ports' single-flit requests for one output link round-robin, gates grants on downstream credit availability, and registers the winning 20-bit flit ({16-bit payload, 4-bit destination}) onto the output link with its valid strobe. The router instantiates one per output port, between the input buffers and the link driver.

## Interface
- N_REQ, 5, number of requesting input ports.
- FLIT_W, 20, flit width in bits.
- CREDIT_MAX, 4, downstream buffer depth; also the credit counter reset value (≥1).

- clk  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-port request; held high with a stable flit until granted.
- flit_in  input  N_REQ*FLIT_W  packed flits; port i occupies bits [i*FLIT_W +: FLIT_W].
- credit_in  input  1  one-cycle pulse; downstream freed one buffer slot.
- gnt  output  N_REQ  one-hot grant, combinational from req/state; the requester's flit is consumed at this clock edge.
- o  output  FLIT_W  registered output flit.
- vo  output  1  registered output valid.
- credits  output  $clog2(CREDIT_MAX+1)  current credit count.
- credit_err  output  1  sticky; set on credit_in while credits == CREDIT_MAX.

## Operation
- State: rr pointer ptr (0..N_REQ-1), credit counter, output register {o, vo}, credit_err.
- Eligibility: a grant issues only if credits > 0 and req != 0; otherwise gnt = 0.
- Selection: scan ports ptr, ptr+1, ..., wrapping mod N_REQ; first port with req high wins; gnt is its one-hot.
- On grant to port k: ptr <= (k+1) mod N_REQ; o <= flit_in[k]; vo <= 1.
- No grant: vo <= 0; o holds its last value; ptr unchanged.
- Credit counter: −1 on grant, +1 on credit_in; both in the same cycle → unchanged.
- Overflow: credit_in with credits == CREDIT_MAX and no grant → credits stay at CREDIT_MAX; credit_err <= 1, cleared only by RST.
- Underflow is impossible by construction: no grant at credits == 0. A credit_in arriving at credits == 0 enables grants from the next cycle, not the same cycle.
- Destination field (flit[3:0]) is passed through unchanged; routing decisions are upstream.
- Reset values: o = 0, vo = 0, gnt = 0 (all state cleared), ptr = 0, credits = CREDIT_MAX, credit_err = 0.

## Timing
- gnt is asserted in the same cycle as the qualifying req. Requester pops its buffer at the edge where gnt is high.
- Flit appears on o with vo = 1 exactly one cycle after the grant cycle.
- Sustained throughput is 1 flit/cycle while credits > 0.
- With no credit return, at most CREDIT_MAX consecutive grants occur before stalling.
- A req dropped before being granted is simply skipped; no state is retained for it.
- RST asserted mid-transfer: immediately (asynchronously) vo = 0 and credits = CREDIT_MAX; any in-flight flit is lost. The first grant may occur in the first cycle after RST deasserts.
- Fairness: a continuously requesting port waits at most N_REQ−1 grants, given credits are available.

## Test plan
- Reset: assert RST mid-stream → o = 0, vo = 0, credits = 4, credit_err = 0, ptr = 0. Next grant with all req high goes to port 0 (gnt = 5'b00001).
- Round-robin: all five req high, CREDIT_MAX = 8, credit_in pulsed every cycle. Port i carries flit {16'd(i+1), 4'd10}. Required grants: 0,1,2,3,4,0,... and o payloads 1,2,3,4,5,1 on consecutive cycles, each one cycle after its grant.
- Sparse requests: ptr = 3, only req[1] and req[4] high → port 4 granted first, then port 1; ptr ends at 2.
- Credit stall: CREDIT_MAX = 4, req[2] held high, no credit_in → 4 grants, then gnt = 0 and vo = 0 with credits = 0. A single credit_in pulse → exactly one more grant on the following cycle.
- Simultaneous grant and credit_in at credits = 2 → credits remains 2.
- Credit overflow: idle at credits = 4, pulse credit_in → credits stays 4, credit_err = 1 and remains set through subsequent traffic until RST.
